hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the in-order RV32 pipeline. It generalises the fixed EX/MEM forwarding and one-cycle load-use logic to configurable forwarding depth, load latency and a multi-cycle multiplier. It sits beside the decode stage and tracks every in-flight writer in an internal shadow pipeline. It drives the forwarding mux selects, front-end stall, EX bubble/hold and redirect flush.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_tracker.sv | 34 +++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the hazard and forwarding controller
package hazard_pkg;

  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_LOAD = 2'd1,
    OP_MUL  = 2'd2
  } op_class_t;

  // Entry fields are sized for any RAW up to 8 and any load latency up to 254.
  localparam int RD_W  = 8;
  localparam int LAT_W = 8;

  typedef struct packed {
    logic             valid;
    logic [RD_W-1:0]  rd;
    logic             wb_en;
    logic [LAT_W-1:0] lat;
  } tracker_entry_t;

  localparam tracker_entry_t ENTRY_NONE = '0;

  function automatic int fsw_width(input int fwd_stages);
    return $clog2(fwd_stages + 1);
  endfunction

endpackage

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - shadow pipeline of in-flight writers; entry 0 is the EX instruction
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_hold,
  input  logic                        i_insert,
  input  tracker_entry_t              i_new,
  output tracker_entry_t [DEPTH-1:0]  o_ent
);

  tracker_entry_t [DEPTH-1:0] r_ent;

  // While EX is held the producer stays put and an empty slot opens behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent <= '0;
    end else begin
      if (!i_hold) begin
        r_ent[0] <= i_insert ? i_new : ENTRY_NONE;
      end
      r_ent[1] <= i_hold ? ENTRY_NONE : r_ent[0];
      for (int k = 2; k < DEPTH; k++) begin
        r_ent[k] <= r_ent[k-1];
      end
    end
  end

  assign o_ent = r_ent;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding select, load-use/multiplier stall and redirect flush control
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int  FWD_STAGES = 3,
  parameter int  LOAD_LAT   = 1,
  parameter int  MUL_CYCLES = 4,
  parameter int  RAW        = 5,
  localparam int FSW        = fsw_width(FWD_STAGES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_id_valid,
  input  logic [RAW-1:0] i_id_rs1,
  input  logic [RAW-1:0] i_id_rs2,
  input  logic           i_id_rs1_used,
  input  logic           i_id_rs2_used,
  input  logic [RAW-1:0] i_id_rd,
  input  logic           i_id_wb_en,
  input  logic [1:0]     i_id_class,
  input  logic           i_ex_redirect,
  output logic [FSW-1:0] o_fwd1_sel,
  output logic [FSW-1:0] o_fwd2_sel,
  output logic           o_stall_front,
  output logic           o_bubble_ex,
  output logic           o_hold_ex,
  output logic           o_flush_front,
  output logic [31:0]    o_stall_count
);

  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  tracker_entry_t [FWD_STAGES-1:0] w_ent;
  tracker_entry_t                  w_new;
  op_class_t                       w_class;
  logic [FSW-1:0]                  w_dist1;
  logic [FSW-1:0]                  w_dist2;
  logic                            w_haz1;
  logic                            w_haz2;
  logic                            w_redirect;
  logic                            w_hold;
  logic                            w_raw_stall;
  logic                            w_issue;
  logic                            w_stall_front;
  logic [FSW-1:0]                  r_fwd1_sel;
  logic [FSW-1:0]                  r_fwd2_sel;
  logic [MCW-1:0]                  r_mul_cnt;
  logic [31:0]                     r_stall_count;

  function automatic logic hits(input tracker_entry_t e, input logic [RAW-1:0] rs,
                                input logic used);
    return used && e.valid && e.wb_en && (rs != '0) && (e.rd == RD_W'(rs));
  endfunction

  assign w_class = op_class_t'(i_id_class);

  // Walk oldest to youngest so the nearest producer overwrites; older ones never matter.
  always_comb begin
    w_dist1 = '0;
    w_dist2 = '0;
    w_haz1  = 1'b0;
    w_haz2  = 1'b0;
    for (int j = FWD_STAGES - 1; j >= 0; j--) begin
      if (hits(w_ent[j], i_id_rs1, i_id_rs1_used)) begin
        w_dist1 = FSW'(j + 1);
        w_haz1  = (j + 1) < int'(w_ent[j].lat);
      end
      if (hits(w_ent[j], i_id_rs2, i_id_rs2_used)) begin
        w_dist2 = FSW'(j + 1);
        w_haz2  = (j + 1) < int'(w_ent[j].lat);
      end
    end
  end

  assign w_redirect    = i_ex_redirect && !rst;
  assign w_hold        = (r_mul_cnt != '0) && !w_redirect;
  assign w_raw_stall   = i_id_valid && (w_haz1 || w_haz2) && !w_redirect && !w_hold;
  assign w_issue       = i_id_valid && !w_redirect && !w_hold && !w_raw_stall;
  assign w_stall_front = w_hold || w_raw_stall;

  always_comb begin
    w_new       = ENTRY_NONE;
    w_new.valid = 1'b1;
    w_new.rd    = RD_W'(i_id_rd);
    w_new.wb_en = i_id_wb_en;
    w_new.lat   = (w_class == OP_LOAD) ? LAT_W'(1 + LOAD_LAT) : LAT_W'(1);
  end

  hazard_tracker #(
    .DEPTH (FWD_STAGES)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (w_hold),
    .i_insert (w_issue),
    .i_new    (w_new),
    .o_ent    (w_ent)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd1_sel    <= '0;
      r_fwd2_sel    <= '0;
      r_mul_cnt     <= '0;
      r_stall_count <= '0;
    end else begin
      // Selects stay frozen while the multiplier owns EX.
      if (w_issue) begin
        r_fwd1_sel <= w_dist1;
        r_fwd2_sel <= w_dist2;
      end else if (!w_hold) begin
        r_fwd1_sel <= '0;
        r_fwd2_sel <= '0;
      end
      if (w_issue && (w_class == OP_MUL) && (MUL_CYCLES > 1)) begin
        r_mul_cnt <= MCW'(MUL_CYCLES - 1);
      end else if (r_mul_cnt != '0) begin
        r_mul_cnt <= r_mul_cnt - MCW'(1);
      end
      if (w_stall_front && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign o_fwd1_sel    = r_fwd1_sel;
  assign o_fwd2_sel    = r_fwd2_sel;
  assign o_stall_front = w_stall_front;
  assign o_bubble_ex   = w_raw_stall;
  assign o_hold_ex     = w_hold;
  assign o_flush_front = w_redirect;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench; dut_a has LOAD_LAT=1, dut_b has LOAD_LAT=2
module tb_hazard_ctrl;

  localparam int FSW = $clog2(3 + 1);
  localparam int C_ALU = 0, C_LOAD = 1, C_MUL = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           id_valid = 1'b0;
  logic [4:0]     id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic           id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_wb_en = 1'b0;
  logic [1:0]     id_class = '0;
  logic           ex_redirect = 1'b0;

  logic [FSW-1:0] a_f1, a_f2, b_f1, b_f2;
  logic           a_sf, a_bx, a_hx, a_ff, b_sf, b_bx, b_hx, b_ff;
  logic [31:0]    a_cnt, b_cnt;

  typedef struct {
    int     cyc;
    int     dut;
    string  name;
    longint sf, bx, hx, ff, f1, f2, cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hazard_ctrl #(.FWD_STAGES(3), .LOAD_LAT(1), .MUL_CYCLES(4), .RAW(5)) dut_a (
    .clk(clk), .rst(rst), .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used), .i_id_rd(id_rd),
    .i_id_wb_en(id_wb_en), .i_id_class(id_class), .i_ex_redirect(ex_redirect),
    .o_fwd1_sel(a_f1), .o_fwd2_sel(a_f2), .o_stall_front(a_sf), .o_bubble_ex(a_bx),
    .o_hold_ex(a_hx), .o_flush_front(a_ff), .o_stall_count(a_cnt));

  hazard_ctrl #(.FWD_STAGES(3), .LOAD_LAT(2), .MUL_CYCLES(4), .RAW(5)) dut_b (
    .clk(clk), .rst(rst), .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used), .i_id_rd(id_rd),
    .i_id_wb_en(id_wb_en), .i_id_class(id_class), .i_ex_redirect(ex_redirect),
    .o_fwd1_sel(b_f1), .o_fwd2_sel(b_f2), .o_stall_front(b_sf), .o_bubble_ex(b_bx),
    .o_hold_ex(b_hx), .o_flush_front(b_ff), .o_stall_count(b_cnt));

  task automatic cmp(input string nm, input string fld, input longint act, input longint want);
    if (want >= 0 && act != want) begin
      n_err++;
      $display("FAIL %s.%s: got %0d want %0d (cycle %0d)", nm, fld, act, want, cyc);
    end
  endtask

  // Monitor: pops every expectation tagged for the current cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_vec++;
        if (e.cyc != cyc) begin
          n_err++;
          $display("FAIL %s.stale: got cycle %0d want cycle %0d", e.name, cyc, e.cyc);
        end else if (e.dut == 0) begin
          cmp(e.name, "a_stall_front", longint'(a_sf), e.sf);
          cmp(e.name, "a_bubble_ex",   longint'(a_bx), e.bx);
          cmp(e.name, "a_hold_ex",     longint'(a_hx), e.hx);
          cmp(e.name, "a_flush_front", longint'(a_ff), e.ff);
          cmp(e.name, "a_fwd1_sel",    longint'(a_f1), e.f1);
          cmp(e.name, "a_fwd2_sel",    longint'(a_f2), e.f2);
          cmp(e.name, "a_stall_count", longint'(a_cnt), e.cnt);
        end else begin
          cmp(e.name, "b_stall_front", longint'(b_sf), e.sf);
          cmp(e.name, "b_bubble_ex",   longint'(b_bx), e.bx);
          cmp(e.name, "b_hold_ex",     longint'(b_hx), e.hx);
          cmp(e.name, "b_flush_front", longint'(b_ff), e.ff);
          cmp(e.name, "b_fwd1_sel",    longint'(b_f1), e.f1);
          cmp(e.name, "b_fwd2_sel",    longint'(b_f2), e.f2);
          cmp(e.name, "b_stall_count", longint'(b_cnt), e.cnt);
        end
      end
    end
  end

  task automatic ex(input int dut, input string nm, input longint sf, bx, hx, ff, f1, f2,
                    input longint cnt);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.name = nm;
    e.sf = sf; e.bx = bx; e.hx = hx; e.ff = ff; e.f1 = f1; e.f2 = f2; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic ins(input int v, rd, rs1, u1, rs2, u2, wb, cls, red);
    @(posedge clk); #1;
    id_valid = 1'(v); id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs1_used = 1'(u1);
    id_rs2 = 5'(rs2); id_rs2_used = 1'(u2); id_wb_en = 1'(wb); id_class = 2'(cls);
    ex_redirect = 1'(red);
  endtask

  task automatic idle();
    ins(0, 0, 0, 0, 0, 0, 0, C_ALU, 0);
  endtask

  task automatic alu(input int rd, rs1, rs2);
    ins(1, rd, rs1, 1, rs2, 1, 1, C_ALU, 0);
  endtask

  initial begin
    // Reset
    @(posedge clk); #1;
    ex(0, "reset", 0, 0, 0, 0, 0, 0, 0); ex(1, "reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; rst = 1'b0;

    // ALU producer then consumer at distance 1
    alu(5, 1, 2);
    ex(0, "s1_prod", 0, 0, 0, 0, 0, 0, 0); ex(1, "s1_prod", 0, 0, 0, 0, 0, 0, 0);
    alu(6, 5, 1);
    ex(0, "s1_cons", 0, 0, 0, 0, 0, 0, 0); ex(1, "s1_cons", 0, 0, 0, 0, 0, 0, 0);
    idle();
    ex(0, "s1_fwd", 0, 0, 0, 0, 1, 0, 0); ex(1, "s1_fwd", 0, 0, 0, 0, 1, 0, 0);
    idle();
    ex(0, "s1_idle", 0, 0, 0, 0, 0, 0, 0); ex(1, "s1_idle", 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Load-use: one stall on dut_a, two on dut_b
    ins(1, 6, 1, 1, 0, 0, 1, C_LOAD, 0);
    ex(0, "lu_load", 0, 0, 0, 0, 0, 0, 0); ex(1, "lu_load", 0, 0, 0, 0, 0, 0, 0);
    alu(7, 6, 6);
    ex(0, "lu_stall1", 1, 1, 0, 0, 0, 0, 0); ex(1, "lu_stall1", 1, 1, 0, 0, 0, 0, 0);
    alu(7, 6, 6);
    ex(0, "lu_issue", 0, 0, 0, 0, 0, 0, 1); ex(1, "lu_stall2", 1, 1, 0, 0, 0, 0, 1);
    alu(7, 6, 6);
    ex(0, "lu_fwd", 0, 0, 0, 0, 2, 2, 1); ex(1, "lu_issue", 0, 0, 0, 0, 0, 0, 2);
    idle();
    ex(0, "lu_after", 0, 0, 0, 0, -1, -1, 1); ex(1, "lu_fwd", 0, 0, 0, 0, 3, 3, 2);
    idle(); idle();

    // Multiplier occupancy then dependent ALU op
    ins(1, 8, 1, 1, 2, 1, 1, C_MUL, 0);
    ex(0, "mul_issue", 0, 0, 0, 0, 0, 0, 1); ex(1, "mul_issue", 0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      alu(9, 8, 0);
      ex(0, "mul_hold", 1, 0, 1, 0, 0, 0, 1 + i); ex(1, "mul_hold", 1, 0, 1, 0, 0, 0, 2 + i);
    end
    alu(9, 8, 0);
    ex(0, "mul_dep", 0, 0, 0, 0, 0, 0, 4); ex(1, "mul_dep", 0, 0, 0, 0, 0, 0, 5);
    idle();
    ex(0, "mul_fwd", 0, 0, 0, 0, 1, 0, 4); ex(1, "mul_fwd", 0, 0, 0, 0, 1, 0, 5);
    idle(); idle();

    // Redirect in a would-be load-use stall
    ins(1, 10, 1, 1, 0, 0, 1, C_LOAD, 0);
    ex(0, "rd_load", 0, 0, 0, 0, 0, 0, 4); ex(1, "rd_load", 0, 0, 0, 0, 0, 0, 5);
    ins(1, 11, 10, 1, 2, 1, 1, C_ALU, 1);
    ex(0, "redirect", 0, 0, 0, 1, 0, 0, 4); ex(1, "redirect", 0, 0, 0, 1, 0, 0, 5);
    alu(12, 3, 4);
    ex(0, "post_redir", 0, 0, 0, 0, 0, 0, 4); ex(1, "post_redir", 0, 0, 0, 0, 0, 0, 5);
    idle();
    ex(0, "redir_cnt", 0, 0, 0, 0, 0, 0, 4); ex(1, "redir_cnt", 0, 0, 0, 0, 0, 0, 5);
    idle(); idle();

    // Nearest of two x3 producers, then x0 producer and unused source
    alu(3, 1, 2);
    alu(3, 1, 2);
    alu(13, 3, 3);
    ex(0, "near_cons", 0, 0, 0, 0, 0, 0, 4); ex(1, "near_cons", 0, 0, 0, 0, 0, 0, 5);
    idle();
    ex(0, "near_x3", 0, 0, 0, 0, 1, 1, 4); ex(1, "near_x3", 0, 0, 0, 0, 1, 1, 5);
    alu(0, 1, 2);
    ins(1, 14, 0, 1, 13, 0, 1, C_ALU, 0);
    idle();
    ex(0, "x0_unused", 0, 0, 0, 0, 0, 0, 4); ex(1, "x0_unused", 0, 0, 0, 0, 0, 0, 5);
    idle(); idle();

    // Reset during a multiply whose operands were forwarded
    alu(15, 1, 2);
    ins(1, 16, 15, 1, 15, 1, 1, C_MUL, 0);
    ex(0, "rm_issue", 0, 0, 0, 0, 0, 0, 4); ex(1, "rm_issue", 0, 0, 0, 0, 0, 0, 5);
    idle();
    ex(0, "rm_hold1", 1, 0, 1, 0, 1, 1, 4); ex(1, "rm_hold1", 1, 0, 1, 0, 1, 1, 5);
    idle();
    ex(0, "rm_hold2", 1, 0, 1, 0, 1, 1, 5); ex(1, "rm_hold2", 1, 0, 1, 0, 1, 1, 6);
    @(posedge clk); #1; rst = 1'b1;
    ex(0, "rst_mid_mul", 0, 0, 0, 0, 0, 0, 0); ex(1, "rst_mid_mul", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; rst = 1'b0;
    ex(0, "post_rst", 0, 0, 0, 0, 0, 0, 0); ex(1, "post_rst", 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
